rx_symbol_sync: RTL and testbench

Receive-side counterpart of the transmit polyphase FIR pulse shaper. Takes the oversampled, matched-filtered stream at OS samples per symbol and estimates the best sampling phase by per-phase energy accumulation. It decimates to one sample per symbol at that phase and slices each sample to a hard BPSK bit. It sits between the RX FIR output and the BER/bit-checker logic.

---
 rtl/rx_symbol_sync.sv | 128 ++++++++++++
 tb/tb_rx_symbol_sync.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/rx_symbol_sync.sv
// rtl/rx_symbol_sync.sv - BPSK symbol timing recovery by per-phase energy accumulation, decimation and hard slicing
// Optional soft-sample output enabled by defining RX_SYMBOL_SYNC_SOFT_OUT_EN.
module rx_symbol_sync #(
  parameter int NB_INPUT   = 8,
  parameter int NBF_INPUT  = 7,
  parameter int OS         = 4,
  parameter int NB_PHASE   = 2,
  parameter int LOG2_N_SYM = 10
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic [NB_INPUT-1:0] i_data,
  input  logic                i_auto,
  input  logic [NB_PHASE-1:0] i_phase_sel,
  output logic                o_bit,
  output logic                o_valid,
  output logic [NB_PHASE-1:0] o_phase,
`ifdef RX_SYMBOL_SYNC_SOFT_OUT_EN
  output logic [NB_INPUT-1:0] o_soft,
`endif
  output logic                o_locked
);

  localparam int MAG_W = NB_INPUT - 1;
  localparam int ACC_W = NB_INPUT - 1 + LOG2_N_SYM;
  localparam logic [NB_PHASE-1:0] LAST_PHASE = NB_PHASE'(OS - 1);
  localparam logic [NB_INPUT-1:0] MOST_NEG = {1'b1, {(NB_INPUT-1){1'b0}}};

  if (OS != (1 << NB_PHASE) || OS < 2 || NBF_INPUT >= NB_INPUT) begin : g_param_check
    $error("rx_symbol_sync: invalid parameter set");
  end

  typedef enum logic {
    SEARCH = 1'b0,
    TRACK  = 1'b1
  } state_t;

  state_t                  state;
  logic [NB_PHASE-1:0]     cnt;
  logic [LOG2_N_SYM-1:0]   sym_cnt;
  logic [ACC_W-1:0]        acc     [OS];
  logic [ACC_W-1:0]        acc_nxt [OS];
  logic [NB_PHASE-1:0]     best_phase;
  logic [NB_PHASE-1:0]     arg_idx;
  logic [ACC_W-1:0]        arg_val;
  logic [MAG_W-1:0]        mag;
  logic [NB_PHASE-1:0]     sel;
  logic                    win_end;
  logic                    hit;

  // Most negative code has no positive twin; clamp it to full scale.
  always_comb begin
    mag = i_data[NB_INPUT-2:0];
    if (i_data[NB_INPUT-1]) begin
      if (i_data == MOST_NEG) mag = '1;
      else                    mag = MAG_W'(-i_data);
    end
  end

  always_comb begin
    for (int p = 0; p < OS; p++) begin
      acc_nxt[p] = acc[p] + ((cnt == NB_PHASE'(p)) ? ACC_W'(mag) : '0);
    end
  end

  // Strict compare keeps the lowest index on ties.
  always_comb begin
    arg_idx = '0;
    arg_val = acc_nxt[0];
    for (int p = 1; p < OS; p++) begin
      if (acc_nxt[p] > arg_val) begin
        arg_val = acc_nxt[p];
        arg_idx = NB_PHASE'(p);
      end
    end
  end

  assign win_end = (cnt == LAST_PHASE) && (sym_cnt == '1);
  assign sel     = i_auto ? best_phase : i_phase_sel;
  assign hit     = (cnt == sel);

  always_ff @(posedge clock) begin
    if (!i_reset) begin
      state      <= SEARCH;
      cnt        <= '0;
      sym_cnt    <= '0;
      best_phase <= '0;
      for (int p = 0; p < OS; p++) acc[p] <= '0;
      o_bit      <= 1'b0;
      o_valid    <= 1'b0;
      o_phase    <= '0;
      o_locked   <= 1'b0;
`ifdef RX_SYMBOL_SYNC_SOFT_OUT_EN
      o_soft     <= '0;
`endif
    end else if (i_enable) begin
      cnt <= cnt + 1'b1;
      if (cnt == LAST_PHASE) sym_cnt <= sym_cnt + 1'b1;
      for (int p = 0; p < OS; p++) acc[p] <= win_end ? '0 : acc_nxt[p];
      if (win_end) best_phase <= arg_idx;

      case (state)
        SEARCH: begin
          o_locked <= 1'b0;
          if (win_end) begin
            state    <= TRACK;
            o_locked <= 1'b1;
          end
        end
        TRACK:   o_locked <= 1'b1;
        default: state <= SEARCH;
      endcase

      o_phase <= sel;
      o_valid <= hit;
      if (hit) begin
        o_bit <= ~i_data[NB_INPUT-1];
`ifdef RX_SYMBOL_SYNC_SOFT_OUT_EN
        o_soft <= i_data;
`endif
      end
    end else begin
      o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rx_symbol_sync.sv
// tb/tb_rx_symbol_sync.sv - randomized self-checking bench for rx_symbol_sync against a sample-level model
module tb_rx_symbol_sync;
  localparam int NB_INPUT   = 8;
  localparam int OS         = 4;
  localparam int NB_PHASE   = 2;
  localparam int LOG2_N_SYM = 4;
  localparam int WIN        = OS * (1 << LOG2_N_SYM);

  logic                clock = 1'b0;
  logic                i_reset = 1'b0;
  logic                i_enable = 1'b0;
  logic [NB_INPUT-1:0] i_data = '0;
  logic                i_auto = 1'b1;
  logic [NB_PHASE-1:0] i_phase_sel = '0;
  logic                o_bit, o_valid, o_locked;
  logic [NB_PHASE-1:0] o_phase;

  always #5 clock = ~clock;

  rx_symbol_sync #(
    .NB_INPUT(NB_INPUT), .NBF_INPUT(7), .OS(OS), .NB_PHASE(NB_PHASE), .LOG2_N_SYM(LOG2_N_SYM)
  ) dut (
    .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_data(i_data),
    .i_auto(i_auto), .i_phase_sel(i_phase_sel),
    .o_bit(o_bit), .o_valid(o_valid), .o_phase(o_phase), .o_locked(o_locked)
  );

  int n_checks = 0;
  int n_fail   = 0;

  int m_idx;
  int m_energy [OS];
  int m_best;
  bit m_locked;
  bit e_bit, e_valid;
  int e_phase;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_idx = 0;
    m_best = 0;
    m_locked = 0;
    for (int p = 0; p < OS; p++) m_energy[p] = 0;
    e_bit = 0;
    e_valid = 0;
    e_phase = 0;
  endtask

  task automatic step(input bit rst_n, input bit en, input int data);
    int sel, ph, mag, bi;
    logic [31:0] dv;
    @(negedge clock);
    dv = data;
    i_reset  = rst_n;
    i_enable = en;
    i_data   = dv[NB_INPUT-1:0];
    sel = i_auto ? m_best : int'(i_phase_sel);
    @(posedge clock);
    #1;
    if (!rst_n) begin
      model_reset();
    end else if (!en) begin
      e_valid = 0;
    end else begin
      ph = m_idx % OS;
      e_phase = sel;
      e_valid = (ph == sel);
      if (e_valid) e_bit = (data >= 0);
      mag = (data == -128) ? 127 : ((data < 0) ? -data : data);
      m_energy[ph] += mag;
      m_idx++;
      if (m_idx % WIN == 0) begin
        bi = 0;
        for (int p = 1; p < OS; p++) if (m_energy[p] > m_energy[bi]) bi = p;
        m_best = bi;
        for (int p = 0; p < OS; p++) m_energy[p] = 0;
        m_locked = 1;
      end
    end
    check("o_valid", o_valid, e_valid);
    check("o_bit", o_bit, e_bit);
    check("o_phase", o_phase, e_phase);
    check("o_locked", o_locked, m_locked);
  endtask

  function automatic int gen(input int dom, input int n);
    int ph, k;
    ph = n % OS;
    k  = n / OS;
    if (ph == dom) return (k % 2 == 0) ? 115 : -115;
    return ($urandom_range(1, 0) != 0) ? 20 : -20;
  endfunction

  task automatic run_stream(input int dom, input int count);
    for (int i = 0; i < count; i++) step(1, 1, gen(dom, m_idx));
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) step(0, 1, int'($urandom_range(255, 0)) - 128);
  endtask

  initial begin
    model_reset();

    // reset behaviour and auto lock on phase 2
    i_auto = 1;
    do_reset(3);
    check("rst_valid", o_valid, 0);
    check("rst_phase", o_phase, 0);
    run_stream(2, WIN - 1);
    check("auto_lock_pre", o_locked, 0);
    run_stream(2, 1);
    check("auto_lock_at_64", o_locked, 1);
    run_stream(2, 1);
    check("auto_phase", o_phase, 2);
    run_stream(2, 40);

    // manual phase 1
    i_auto = 0;
    i_phase_sel = 1;
    do_reset(1);
    run_stream(2, 40);
    check("manual_phase", o_phase, 1);

    // enable gating mid-window
    i_auto = 1;
    do_reset(1);
    run_stream(2, 30);
    for (int i = 0; i < 5; i++) step(1, 0, gen(2, m_idx));
    run_stream(2, WIN - 31);
    check("gate_lock_pre", o_locked, 0);
    run_stream(2, 1);
    check("gate_lock_at_64", o_locked, 1);

    // tie: all phases at most negative code
    do_reset(1);
    for (int i = 0; i < WIN + 1; i++) step(1, 1, -128);
    check("tie_phase", o_phase, 0);
    check("tie_locked", o_locked, 1);

    // saturation: |-128| must tie with 127 on phase 1
    do_reset(1);
    for (int i = 0; i < WIN + 1; i++)
      step(1, 1, (m_idx % OS == 0) ? -128 : ((m_idx % OS == 1) ? 127 : 0));
    check("sat_phase", o_phase, 0);

    // reset during TRACK, then dominant phase 3
    do_reset(1);
    check("retrack_unlocked", o_locked, 0);
    run_stream(3, WIN - 1);
    check("retrack_lock_pre", o_locked, 0);
    run_stream(3, 1);
    check("retrack_lock_at_64", o_locked, 1);
    run_stream(3, 1);
    check("retrack_phase", o_phase, 3);

    // random data, random gating, random auto/manual switching
    do_reset(1);
    for (int i = 0; i < 3 * WIN + 20; i++) begin
      i_auto = ($urandom_range(3, 0) != 0);
      i_phase_sel = NB_PHASE'($urandom_range(OS - 1, 0));
      step(1, ($urandom_range(7, 0) != 0), int'($urandom_range(255, 0)) - 128);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
